// File: rtl/pulp_cluster_package.sv
// -----------------------------------------------------------------------------
// pulp_cluster_package
// Shared definitions for the cluster peripheral scheduler: peripheral slave
// count and index map, the error response word, the scheduler FSM state
// encoding and the address-to-slave decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package pulp_cluster_package;

   localparam int NB_SPERIPHS = 10;

   localparam int SPER_EOC_ID         = 0;
   localparam int SPER_TIMER_ID       = 1;
   localparam int SPER_EVENT_U_ID     = 2;   // two consecutive windows: 2 and 3
   localparam int SPER_HWPE_ID        = 4;
   localparam int SPER_ICACHE_CTRL_ID = 5;
   localparam int SPER_DMA_CL_ID      = 6;
   localparam int SPER_DMA_FC_ID      = 7;
   localparam int SPER_DECOMP_ID      = 8;
   localparam int SPER_EXT_ID         = 9;
   localparam int SPER_ERROR_ID       = NB_SPERIPHS;

   localparam logic [31:0] SPER_ERROR_DATA = 32'hBADACCE5;

   typedef enum logic [1:0] {
      SCHED_IDLE,
      SCHED_REQ,
      SCHED_RESP,
      SCHED_ERR
   } sched_state_e;

   // 1 KiB peripheral windows: slave index lives in address bits [13:10]
   function automatic logic [3:0] sper_index(input logic [31:0] addr);
      return addr[13:10];
   endfunction

endpackage

// File: rtl/periph_rr_picker.sv
// -----------------------------------------------------------------------------
// periph_rr_picker
// Round-robin request picker: scans the request vector starting at the
// pointer position (wrapping) and returns the first requester.
// Ports:
//   req_i    in  NB_MASTERS  request vector
//   ptr_i    in  PTR_W       position with highest priority
//   gnt_o    out NB_MASTERS  one-hot winner (all zero when no request)
//   valid_o  out 1           a winner exists
// -----------------------------------------------------------------------------
module periph_rr_picker #(
   parameter int NB_MASTERS = 8,
   parameter int PTR_W      = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1
) (
   input  logic [NB_MASTERS-1:0] req_i,
   input  logic [PTR_W-1:0]      ptr_i,
   output logic [NB_MASTERS-1:0] gnt_o,
   output logic                  valid_o
);

   logic [PTR_W-1:0] pos;

   always_comb begin
      gnt_o   = '0;
      valid_o = 1'b0;
      pos     = '0;
      for (int unsigned k = 0; k < NB_MASTERS; k++) begin
         pos = PTR_W'((32'(ptr_i) + k) % NB_MASTERS);
         if (!valid_o && req_i[pos]) begin
            gnt_o[pos] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cluster_periph_sched.sv
// -----------------------------------------------------------------------------
// cluster_periph_sched
// Serialises core accesses to the cluster peripherals: one transaction in
// flight, round-robin arbitration among masters, address-decoded slave
// select, error response for unmapped windows and for slaves that do not
// answer within TIMEOUT cycles of the grant.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   m_req_i/m_add_i/m_wen_i/
//   m_wdata_i/m_be_i                   per-master request payload (wen 1=read)
//   m_gnt_o                            one-hot grant (IDLE only)
//   m_r_valid_o/m_r_rdata_o/m_r_opc_o  response to the winning master (opc 1=error)
//   s_req_o/s_add_o/s_wen_o/
//   s_wdata_o/s_be_o                   request to the selected slave
//   s_gnt_i/s_r_valid_i/
//   s_r_rdata_i/s_r_opc_i              per-slave handshake and response
// -----------------------------------------------------------------------------
module cluster_periph_sched
   import pulp_cluster_package::*;
#(
   parameter int NB_MASTERS  = 8,
   parameter int NB_SPERIPHS = pulp_cluster_package::NB_SPERIPHS,
   parameter int TIMEOUT     = 255
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NB_MASTERS-1:0]       m_req_i,
   input  logic [NB_MASTERS-1:0][31:0] m_add_i,
   input  logic [NB_MASTERS-1:0]       m_wen_i,
   input  logic [NB_MASTERS-1:0][31:0] m_wdata_i,
   input  logic [NB_MASTERS-1:0][3:0]  m_be_i,
   output logic [NB_MASTERS-1:0]       m_gnt_o,
   output logic [NB_MASTERS-1:0]       m_r_valid_o,
   output logic [31:0]                 m_r_rdata_o,
   output logic                        m_r_opc_o,
   output logic [NB_SPERIPHS-1:0]      s_req_o,
   output logic [31:0]                 s_add_o,
   output logic                        s_wen_o,
   output logic [31:0]                 s_wdata_o,
   output logic [3:0]                  s_be_o,
   input  logic [NB_SPERIPHS-1:0]      s_gnt_i,
   input  logic [NB_SPERIPHS-1:0]      s_r_valid_i,
   input  logic [NB_SPERIPHS-1:0][31:0] s_r_rdata_i,
   input  logic [NB_SPERIPHS-1:0]      s_r_opc_i
);

   localparam int IW = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

   sched_state_e  state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] win_q, win_d;
   logic [3:0]    idx_q, idx_d;
   logic [31:0]   add_q, add_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          wen_q, wen_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   cnt_q, cnt_d;

   logic [NB_MASTERS-1:0] pick_oh;
   logic                  pick_valid;

   periph_rr_picker #(
      .NB_MASTERS (NB_MASTERS),
      .PTR_W      (IW)
   ) i_picker (
      .req_i   (m_req_i),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_oh),
      .valid_o (pick_valid)
   );

   // Encoded winner and its payload
   logic [IW-1:0] pick_idx;
   logic [31:0]   pick_add, pick_wdata;
   logic          pick_wen;
   logic [3:0]    pick_be;

   always_comb begin
      pick_idx   = '0;
      pick_add   = '0;
      pick_wdata = '0;
      pick_wen   = 1'b0;
      pick_be    = '0;
      for (int unsigned k = 0; k < NB_MASTERS; k++) begin
         if (pick_oh[k]) begin
            pick_idx   = IW'(k);
            pick_add   = m_add_i[k];
            pick_wdata = m_wdata_i[k];
            pick_wen   = m_wen_i[k];
            pick_be    = m_be_i[k];
         end
      end
   end

   // Handshake of the latched slave only; everything else is ignored
   logic        sel_gnt, sel_valid, sel_opc;
   logic [31:0] sel_rdata;

   always_comb begin
      sel_gnt   = 1'b0;
      sel_valid = 1'b0;
      sel_opc   = 1'b0;
      sel_rdata = '0;
      for (int unsigned k = 0; k < NB_SPERIPHS; k++) begin
         if (idx_q == 4'(k)) begin
            sel_gnt   = s_gnt_i[k];
            sel_valid = s_r_valid_i[k];
            sel_opc   = s_r_opc_i[k];
            sel_rdata = s_r_rdata_i[k];
         end
      end
   end

   // Counter is 0 in the first cycle after the grant, so the TIMEOUT-th
   // waiting cycle is the one where it reads TIMEOUT-1.
   logic timeout;
   assign timeout = (cnt_q == 32'(TIMEOUT - 1));

   logic        gnt_en, sreq_en, resp_valid, resp_opc;
   logic [31:0] resp_rdata;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      idx_d      = idx_q;
      add_d      = add_q;
      wdata_d    = wdata_q;
      wen_d      = wen_q;
      be_d       = be_q;
      cnt_d      = cnt_q;
      gnt_en     = 1'b0;
      sreq_en    = 1'b0;
      resp_valid = 1'b0;
      resp_opc   = 1'b0;
      resp_rdata = '0;

      unique case (state_q)
         SCHED_IDLE: begin
            if (pick_valid) begin
               gnt_en  = 1'b1;
               ptr_d   = (pick_idx == IW'(NB_MASTERS - 1)) ? '0 : pick_idx + IW'(1);
               win_d   = pick_idx;
               idx_d   = sper_index(pick_add);
               add_d   = pick_add;
               wdata_d = pick_wdata;
               wen_d   = pick_wen;
               be_d    = pick_be;
               cnt_d   = '0;
               state_d = ({28'd0, sper_index(pick_add)} < 32'(SPER_ERROR_ID)) ? SCHED_REQ : SCHED_ERR;
            end
         end
         SCHED_REQ: begin
            cnt_d = cnt_q + 32'd1;
            if (timeout) begin
               resp_valid = 1'b1;
               resp_rdata = SPER_ERROR_DATA;
               resp_opc   = 1'b1;
               state_d    = SCHED_IDLE;
            end else begin
               sreq_en = 1'b1;
               if (sel_gnt) state_d = SCHED_RESP;
            end
         end
         SCHED_RESP: begin
            cnt_d = cnt_q + 32'd1;
            // a response arriving in the timeout cycle is still delivered
            if (sel_valid) begin
               resp_valid = 1'b1;
               resp_rdata = sel_rdata;
               resp_opc   = sel_opc;
               state_d    = SCHED_IDLE;
            end else if (timeout) begin
               resp_valid = 1'b1;
               resp_rdata = SPER_ERROR_DATA;
               resp_opc   = 1'b1;
               state_d    = SCHED_IDLE;
            end
         end
         SCHED_ERR: begin
            resp_valid = 1'b1;
            resp_rdata = SPER_ERROR_DATA;
            resp_opc   = 1'b1;
            state_d    = SCHED_IDLE;
         end
         default: state_d = SCHED_IDLE;
      endcase

      // a transaction cut by reset is abandoned silently
      if (rst_i) begin
         gnt_en     = 1'b0;
         sreq_en    = 1'b0;
         resp_valid = 1'b0;
         resp_opc   = 1'b0;
         resp_rdata = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SCHED_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         idx_q   <= '0;
         add_q   <= '0;
         wdata_q <= '0;
         wen_q   <= 1'b0;
         be_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         idx_q   <= idx_d;
         add_q   <= add_d;
         wdata_q <= wdata_d;
         wen_q   <= wen_d;
         be_q    <= be_d;
         cnt_q   <= cnt_d;
      end
   end

   assign m_gnt_o     = gnt_en ? pick_oh : '0;
   assign m_r_rdata_o = resp_rdata;
   assign m_r_opc_o   = resp_opc;
   assign s_add_o     = add_q;
   assign s_wdata_o   = wdata_q;
   assign s_wen_o     = wen_q;
   assign s_be_o      = be_q;

   always_comb begin
      m_r_valid_o = '0;
      for (int unsigned k = 0; k < NB_MASTERS; k++) begin
         m_r_valid_o[k] = resp_valid && (win_q == IW'(k));
      end
   end

   always_comb begin
      s_req_o = '0;
      for (int unsigned k = 0; k < NB_SPERIPHS; k++) begin
         s_req_o[k] = sreq_en && (idx_q == 4'(k));
      end
   end

endmodule

// File: tb/tb_cluster_periph_sched.sv
// -----------------------------------------------------------------------------
// tb_cluster_periph_sched
// Randomized self-checking bench for cluster_periph_sched against a
// transaction-level reference model (round-robin scan, cycle count since
// grant, address window decode).
// -----------------------------------------------------------------------------
module tb_cluster_periph_sched;

   localparam int NM = 8;
   localparam int NS = 10;
   localparam int TO = 255;
   localparam logic [31:0] ERR_WORD = 32'hBADACCE5;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic [NM-1:0]       m_req_i, m_wen_i, m_gnt_o, m_r_valid_o;
   logic [NM-1:0][31:0] m_add_i, m_wdata_i;
   logic [NM-1:0][3:0]  m_be_i;
   logic [31:0]         m_r_rdata_o;
   logic                m_r_opc_o;
   logic [NS-1:0]       s_req_o, s_gnt_i, s_r_valid_i, s_r_opc_i;
   logic [31:0]         s_add_o, s_wdata_o;
   logic                s_wen_o;
   logic [3:0]          s_be_o;
   logic [NS-1:0][31:0] s_r_rdata_i;

   cluster_periph_sched #(
      .NB_MASTERS  (NM),
      .NB_SPERIPHS (NS),
      .TIMEOUT     (TO)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .m_req_i     (m_req_i),
      .m_add_i     (m_add_i),
      .m_wen_i     (m_wen_i),
      .m_wdata_i   (m_wdata_i),
      .m_be_i      (m_be_i),
      .m_gnt_o     (m_gnt_o),
      .m_r_valid_o (m_r_valid_o),
      .m_r_rdata_o (m_r_rdata_o),
      .m_r_opc_o   (m_r_opc_o),
      .s_req_o     (s_req_o),
      .s_add_o     (s_add_o),
      .s_wen_o     (s_wen_o),
      .s_wdata_o   (s_wdata_o),
      .s_be_o      (s_be_o),
      .s_gnt_i     (s_gnt_i),
      .s_r_valid_i (s_r_valid_i),
      .s_r_rdata_i (s_r_rdata_i),
      .s_r_opc_i   (s_r_opc_i)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model state ----------------
   int          rr_ptr;
   logic [31:0] last_add, last_wdata;
   logic [3:0]  last_be;
   logic        last_wen;
   logic [31:0] obs_gnt;

   function automatic int rr_pick(input logic [NM-1:0] req, input int ptr);
      for (int i = 0; i < NM; i++) begin
         int m;
         m = (ptr + i) % NM;
         if (req[m]) return m;
      end
      return -1;
   endfunction

   task automatic model_reset();
      rr_ptr     = 0;
      last_add   = '0;
      last_wdata = '0;
      last_be    = '0;
      last_wen   = 1'b0;
   endtask

   task automatic drive_noise();
      s_gnt_i     = NS'($urandom);
      s_r_valid_i = NS'($urandom);
      s_r_opc_i   = NS'($urandom);
      for (int k = 0; k < NS; k++) s_r_rdata_i[k] = $urandom;
   endtask

   task automatic set_master(input int m, input logic [31:0] addr);
      m_add_i[m]   = addr;
      m_wdata_i[m] = $urandom;
      m_wen_i[m]   = 1'($urandom);
      m_be_i[m]    = 4'($urandom);
   endtask

   task automatic randomize_masters();
      for (int m = 0; m < NM; m++) begin
         logic [31:0] a;
         a        = $urandom;
         a[13:10] = 4'($urandom_range(0, 12));
         set_master(m, a);
      end
   endtask

   task automatic expect_err(input int w);
      check_eq("err_valid", m_r_valid_o, 32'(1) << w);
      check_eq("err_rdata", m_r_rdata_o, ERR_WORD);
      check_eq("err_opc", m_r_opc_o, 1'b1);
      check_eq("err_sreq", s_req_o, 0);
   endtask

   // One transaction from the IDLE cycle to the response. gdel/vdel are the
   // slave's grant/response delays in cycles (-1: never).
   task automatic do_txn(input logic [NM-1:0] req, input int gdel, input int vdel,
                         input logic [31:0] rdata, input logic opc, output int w);
      int idx, c, gnt_c;
      bit in_resp, done;
      @(negedge clk_i);
      m_req_i = req;
      drive_noise();
      #1;
      w       = rr_pick(req, rr_ptr);
      obs_gnt = 32'(m_gnt_o);
      check_eq("gnt", m_gnt_o, (w < 0) ? 32'd0 : (32'(1) << w));
      check_eq("idle_valid", m_r_valid_o, 0);
      check_eq("idle_rdata", m_r_rdata_o, 0);
      check_eq("idle_opc", m_r_opc_o, 0);
      check_eq("idle_sreq", s_req_o, 0);
      check_eq("idle_add", s_add_o, last_add);
      check_eq("idle_wdata", s_wdata_o, last_wdata);
      check_eq("idle_be", s_be_o, last_be);
      if (w < 0) return;
      rr_ptr     = (w + 1) % NM;
      idx        = int'(m_add_i[w][13:10]);
      last_add   = m_add_i[w];
      last_wdata = m_wdata_i[w];
      last_be    = m_be_i[w];
      last_wen   = m_wen_i[w];
      in_resp = 1'b0; done = 1'b0; c = 0; gnt_c = 0;
      while (!done) begin
         @(negedge clk_i);
         c++;
         drive_noise();
         if (idx < NS) begin
            if (!in_resp) begin
               s_gnt_i[idx] = (gdel >= 0) && (c == 1 + gdel);
            end else begin
               s_r_valid_i[idx] = (vdel >= 0) && (c == gnt_c + 1 + vdel);
               s_r_rdata_i[idx] = rdata;
               s_r_opc_i[idx]   = opc;
            end
         end
         #1;
         check_eq("busy_gnt", m_gnt_o, 0);
         if (idx >= NS) begin
            expect_err(w);
            done = 1'b1;
         end else if (!in_resp) begin
            if (c == TO) begin
               expect_err(w);
               done = 1'b1;
            end else begin
               check_eq("req_sreq", s_req_o, 32'(1) << idx);
               check_eq("req_add", s_add_o, last_add);
               check_eq("req_wen", s_wen_o, last_wen);
               check_eq("req_wdata", s_wdata_o, last_wdata);
               check_eq("req_be", s_be_o, last_be);
               check_eq("req_valid", m_r_valid_o, 0);
               if (s_gnt_i[idx]) begin
                  in_resp = 1'b1;
                  gnt_c   = c;
               end
            end
         end else begin
            check_eq("resp_sreq", s_req_o, 0);
            if (s_r_valid_i[idx]) begin
               check_eq("resp_valid", m_r_valid_o, 32'(1) << w);
               check_eq("resp_rdata", m_r_rdata_o, rdata);
               check_eq("resp_opc", m_r_opc_o, opc);
               done = 1'b1;
            end else if (c == TO) begin
               expect_err(w);
               done = 1'b1;
            end else begin
               check_eq("wait_valid", m_r_valid_o, 0);
               check_eq("wait_rdata", m_r_rdata_o, 0);
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int exp_seq [4];
      exp_seq = '{0, 1, 7, 0};

      rst_i       = 1'b1;
      m_req_i     = '0;
      m_add_i     = '0;
      m_wen_i     = '0;
      m_wdata_i   = '0;
      m_be_i      = '0;
      s_gnt_i     = '0;
      s_r_valid_i = '0;
      s_r_opc_i   = '0;
      s_r_rdata_i = '0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;

      // reset state
      @(negedge clk_i);
      #1;
      check_eq("rst_gnt", m_gnt_o, 0);
      check_eq("rst_valid", m_r_valid_o, 0);
      check_eq("rst_sreq", s_req_o, 0);
      check_eq("rst_rdata", m_r_rdata_o, 0);
      check_eq("rst_opc", m_r_opc_o, 0);
      check_eq("rst_add", s_add_o, 0);
      check_eq("rst_wdata", s_wdata_o, 0);
      check_eq("rst_be", s_be_o, 0);
      check_eq("rst_wen", s_wen_o, 0);

      // round robin from pointer 0 with masters 0,1,7 requesting
      set_master(0, 32'h1020_0800);
      set_master(1, 32'h1020_0C00);
      set_master(7, 32'h1020_1000);
      for (int i = 0; i < 4; i++) begin
         do_txn(8'b1000_0011, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 1'($urandom), w);
         check_eq("rr_seq", obs_gnt, 32'(1) << exp_seq[i]);
      end

      // minimum latency read from master 3 to slave 1
      set_master(3, 32'h1020_0400);
      m_wen_i[3] = 1'b1;
      do_txn(8'b0000_1000, 0, 0, 32'h0000_1234, 1'b0, w);

      // unmapped window 11
      set_master(2, 32'h1020_2C00);
      do_txn(8'b0000_0100, 0, 0, '0, 1'b0, w);

      // slave 6 never grants: timeout error
      set_master(5, 32'h1020_1800);
      do_txn(8'b0010_0000, -1, 0, '0, 1'b0, w);
      // late handshake from slave 6 while idle is ignored
      @(negedge clk_i);
      m_req_i        = '0;
      s_gnt_i        = '0;
      s_r_valid_i    = '0;
      s_gnt_i[6]     = 1'b1;
      s_r_valid_i[6] = 1'b1;
      #1;
      check_eq("late_valid", m_r_valid_o, 0);
      check_eq("late_sreq", s_req_o, 0);
      check_eq("late_rdata", m_r_rdata_o, 0);

      // response coinciding with the timeout cycle wins
      set_master(4, 32'h1020_1000);
      do_txn(8'b0001_0000, 0, TO - 2, 32'hCAFE_0001, 1'b0, w);

      // no slave response after grant: timeout in RESP
      set_master(6, 32'h1020_2000);
      do_txn(8'b0100_0000, 1, -1, '0, 1'b0, w);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         randomize_masters();
         do_txn(NM'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), $urandom, 1'($urandom), w);
      end

      // reset while waiting for the response
      set_master(5, 32'h1020_0000);
      do_txn(8'b0010_0000, 0, 0, $urandom, 1'b0, w);
      set_master(4, 32'h1020_0800);
      @(negedge clk_i);
      s_gnt_i = '0; s_r_valid_i = '0;
      m_req_i = 8'b0001_0000;
      #1;
      check_eq("pre_rst_gnt", m_gnt_o, 32'h10);
      @(negedge clk_i);
      m_req_i    = '0;
      s_gnt_i[2] = 1'b1;
      #1;
      check_eq("pre_rst_sreq", s_req_o, 32'h4);
      @(negedge clk_i);
      s_gnt_i        = '0;
      s_r_valid_i[2] = 1'b1;
      rst_i          = 1'b1;
      #1;
      check_eq("rst_resp_valid", m_r_valid_o, 0);
      @(posedge clk_i);
      #1;
      rst_i       = 1'b0;
      s_r_valid_i = '0;
      model_reset();
      set_master(1, 32'h1020_0C00);
      set_master(7, 32'h1020_0C00);
      do_txn(8'b1000_0010, 0, 1, $urandom, 1'b0, w);
      check_eq("post_rst_gnt", obs_gnt, 32'h2);

      for (int i = 0; i < 10; i++) begin
         randomize_masters();
         do_txn(NM'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), $urandom, 1'($urandom), w);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cluster_periph_sched.md
CLUSTER_PERIPH_SCHED -- requirements
Module: cluster_periph_sched

Interface
REQ-001 SHALL have parameter NB_MASTERS, default 8, number of requesting cores.
REQ-002 SHALL have parameter NB_SPERIPHS, default 10, number of mapped peripheral slaves, indices 0..9 (EOC, TIMER, EVENT_U x2, HWPE, ICACHE_CTRL, DMA_CL, DMA_FC, DECOMP, EXT).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait cycles per transaction.
REQ-004 SHALL have ports clk_i in 1 clock; rst_i in 1 reset, synchronous, active-high.
REQ-005 SHALL have ports m_req_i in NB_MASTERS; m_add_i in NB_MASTERSx32; m_wen_i in NB_MASTERS (1=read); m_wdata_i in NB_MASTERSx32; m_be_i in NB_MASTERSx4.
REQ-006 SHALL have ports m_gnt_o out NB_MASTERS; m_r_valid_o out NB_MASTERS; m_r_rdata_o out 32; m_r_opc_o out 1 (1=error).
REQ-007 SHALL have ports s_req_o out NB_SPERIPHS; s_add_o out 32; s_wen_o out 1; s_wdata_o out 32; s_be_o out 4; s_gnt_i in NB_SPERIPHS; s_r_valid_i in NB_SPERIPHS; s_r_rdata_i in NB_SPERIPHSx32; s_r_opc_i in NB_SPERIPHS.

Function
REQ-008 SHALL decode slave index from address bits [13:10] (1 KiB windows); index >= NB_SPERIPHS is unmapped (SPER_ERROR_ID path).
REQ-009 SHALL use a four-state FSM: IDLE, REQ, RESP, ERR; one transaction outstanding at a time.
REQ-010 IDLE: if any m_req_i, SHALL pick winner by round-robin starting at pointer, assert m_gnt_o[winner] same cycle, latch payload, winner and slave index.
REQ-011 IDLE transitions: mapped -> REQ; unmapped -> ERR; no request -> stay IDLE, no m_gnt_o.
REQ-012 Round-robin pointer SHALL update to (winner+1) mod NB_MASTERS on each grant, wrapping from NB_MASTERS-1 to 0.
REQ-013 m_gnt_o SHALL be asserted only in IDLE, at most one bit per cycle.
REQ-014 REQ: SHALL drive s_req_o[idx] and latched s_add_o/s_wen_o/s_wdata_o/s_be_o, held stable until s_gnt_i[idx]; then -> RESP.
REQ-015 RESP: on s_r_valid_i[idx], SHALL assert m_r_valid_o[winner] combinationally that cycle with m_r_rdata_o=s_r_rdata_i[idx], m_r_opc_o=s_r_opc_i[idx]; -> IDLE.
REQ-016 ERR: SHALL assert m_r_valid_o[winner] for one cycle with m_r_rdata_o=32'hBADACCE5, m_r_opc_o=1; -> IDLE.
REQ-017 Timeout counter SHALL clear on grant, increment each cycle in REQ/RESP; on reaching TIMEOUT SHALL drop s_req_o, issue the ERR response that cycle, -> IDLE.
REQ-018 If s_r_valid_i[idx] and timeout coincide, the slave response SHALL win.
REQ-019 s_r_valid_i/s_gnt_i on non-selected slaves or outside RESP/REQ SHALL be ignored.
REQ-020 Minimum latency: grant at t, s_req_o at t+1, m_r_valid_o at t+2 (slave gnt at t+1, r_valid at t+2).
REQ-021 When idle, m_r_rdata_o=0, m_r_opc_o=0, s_add_o/s_wdata_o/s_be_o hold last latched values.

Reset
REQ-022 On rst_i high at a clock edge SHALL enter IDLE, pointer=0, counter=0, latched payload=0; all m_gnt_o, m_r_valid_o, s_req_o=0 from the following cycle.
REQ-023 Reset mid-transaction SHALL abandon it with no response to the master.

Structure
REQ-024 NB_SPERIPHS, SPER_*_ID indices, error data 32'hBADACCE5 and the FSM state enum SHALL reside in pulp_cluster_package.
REQ-025 Round-robin selection SHALL be a sub-module rr_arb_tree-free leaf named periph_rr_picker (request vector, pointer in; one-hot winner, valid out).

Verification
REQ-026 Master 3 reads 0x1020_0400 (idx 1), slave gnt at t+1, r_valid at t+2, rdata 0x1234 -> m_r_valid_o[3] at t+2, rdata 0x1234, opc 0.
REQ-027 Masters 0,1,7 request continuously, pointer 0 -> grants 0,1,7,0 across four transactions.
REQ-028 Master 2 accesses 0x1020_2C00 (idx 11) -> no s_req_o, m_r_valid_o[2] at t+1, rdata 0xBADACCE5, opc 1.
REQ-029 Slave 6 never asserts gnt, TIMEOUT=255 -> s_req_o[6] drops, error response 255 cycles after grant; late s_r_valid_i ignored.
REQ-030 rst_i asserted in RESP -> no m_r_valid_o, next cycle IDLE, pointer 0, new request granted immediately.
